osd_spi_ctrl: RTL and testbench

- Local SPI master that sequences OSD commands for boards with no external IO controller.
- Drives the OSD's SPI_SCK/SPI_SS3/SPI_DI pins from a small command port.
- Supports OSD enable, OSD disable and full-line writes. Line bytes are fetched from a core-side menu RAM through a 1-cycle-latency read port.
- Sits between the core's menu logic and the osd block, all in the clk_sys domain.

---
 rtl/osd_pkg.sv | 40 ++++
 rtl/osd_spi_shifter.sv | 70 +++++++
 rtl/osd_spi_ctrl.sv | 144 ++++++++++++++
 tb/tb_osd_spi_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared opcodes, OSD command bytes and controller state encoding
// for the local OSD SPI command sequencer.
package osd_pkg;

    localparam logic [1:0] OSD_OP_DISABLE = 2'd0;
    localparam logic [1:0] OSD_OP_ENABLE  = 2'd1;
    localparam logic [1:0] OSD_OP_WRITE   = 2'd2;
    localparam logic [1:0] OSD_OP_NOP     = 2'd3;

    localparam logic [7:0] OSD_CMD_DISABLE    = 8'h40;
    localparam logic [7:0] OSD_CMD_ENABLE     = 8'h41;
    localparam logic [7:0] OSD_CMD_WRITE_BASE = 8'h20;

    localparam int OSD_LINES      = 8;
    localparam int OSD_LINE_BYTES = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SHIFT,
        ST_FETCH,
        ST_LOAD,
        ST_DESELECT,
        ST_DONE
    } osd_state_e;

    function automatic logic [7:0] osd_cmd_byte(
        input logic [1:0] op,
        input logic [2:0] line
    );
        logic [7:0] b;
        case (op)
            OSD_OP_DISABLE: b = OSD_CMD_DISABLE;
            OSD_OP_ENABLE:  b = OSD_CMD_ENABLE;
            default:        b = OSD_CMD_WRITE_BASE | {5'b00000, line};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/osd_spi_shifter.sv
// Half-period tick divider and 8-bit MSB-first SPI shifter.
// A started byte runs 8 low/high SCK pairs and flags the last high phase.
module osd_spi_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       start,
    input  logic       hold,
    output logic       tick,
    output logic       sck,
    output logic       di,
    output logic       byte_done
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic       active;
    logic       phase;

    assign tick      = (div_cnt == 8'd0);
    assign sck       = active & phase;
    assign di        = sr[7];
    assign byte_done = active & phase & tick & (bit_cnt == 3'd7);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= RELOAD;
            sr      <= 8'h00;
            bit_cnt <= 3'd0;
            active  <= 1'b0;
            phase   <= 1'b0;
        end else begin
            if (start) begin
                active  <= 1'b1;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                div_cnt <= RELOAD;
            end else if (active || hold) begin
                if (tick) begin
                    div_cnt <= RELOAD;
                    if (active) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            // falling edge: next bit appears while SCK is low
                            phase   <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            sr      <= {sr[6:0], 1'b0};
                            if (bit_cnt == 3'd7)
                                active <= 1'b0;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt - 8'd1;
                end
            end else begin
                div_cnt <= RELOAD;
            end
            if (load)
                sr <= load_data;
        end
    end

endmodule

// File: rtl/osd_spi_ctrl.sv
// Local SPI master sequencing OSD enable/disable and full-line writes,
// with line bytes fetched from a 1-cycle-latency menu RAM port.
module osd_spi_ctrl
    import osd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int LINE_BYTES = OSD_LINE_BYTES
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_line,
    output logic        rd_en,
    output logic [10:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        SPI_SCK,
    output logic        SPI_SS3,
    output logic        SPI_DI
);

    osd_state_e state_q, state_d;
    logic [1:0] op_q;
    logic [2:0] line_q;
    logic [8:0] byte_cnt;
    logic       half_q;

    logic       sh_load;
    logic [7:0] sh_data;
    logic       sh_start;
    logic       sh_hold;
    logic       tick;
    logic       byte_done;

    osd_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .load      (sh_load),
        .load_data (sh_data),
        .start     (sh_start),
        .hold      (sh_hold),
        .tick      (tick),
        .sck       (SPI_SCK),
        .di        (SPI_DI),
        .byte_done (byte_done)
    );

    always_comb begin
        state_d  = state_q;
        sh_load  = 1'b0;
        sh_data  = 8'h00;
        sh_start = 1'b0;
        sh_hold  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OSD_OP_NOP) begin
                        state_d = ST_DONE;
                    end else begin
                        sh_load = 1'b1;
                        sh_data = osd_cmd_byte(cmd_op, cmd_line);
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                sh_hold = 1'b1;
                if (tick) begin
                    sh_start = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (byte_done) begin
                    if (op_q == OSD_OP_WRITE &&
                        byte_cnt != 9'(LINE_BYTES))
                        state_d = ST_FETCH;
                    else
                        state_d = ST_DESELECT;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sh_load  = 1'b1;
                sh_data  = rd_data;
                sh_start = 1'b1;
                state_d  = ST_SHIFT;
            end
            ST_DESELECT: begin
                sh_hold = 1'b1;
                if (tick && half_q)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OSD_OP_DISABLE;
            line_q   <= 3'd0;
            byte_cnt <= 9'd0;
            half_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && cmd_valid) begin
                op_q     <= cmd_op;
                line_q   <= cmd_line;
                byte_cnt <= 9'd0;
            end
            if (state_q == ST_LOAD)
                byte_cnt <= byte_cnt + 9'd1;
            // two ticks of deselect give a full bit time with SS3 high
            if (state_q == ST_DESELECT) begin
                if (tick)
                    half_q <= 1'b1;
            end else begin
                half_q <= 1'b0;
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state_q == ST_DONE);
    assign rd_en     = (state_q == ST_FETCH);
    assign rd_addr   = {line_q, byte_cnt[7:0]};
    assign SPI_SS3   = !(state_q == ST_SELECT || state_q == ST_SHIFT ||
                         state_q == ST_FETCH  || state_q == ST_LOAD);

endmodule

// File: tb/tb_osd_spi_ctrl.sv
// Bench for osd_spi_ctrl: two configurations, timeline model,
// OSD SPI receiver model and menu RAM model.
module tb_osd_spi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       vld;
    logic [1:0]       rdy;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       rde;
    logic [1:0]       sck;
    logic [1:0]       ss3;
    logic [1:0]       di;
    logic [1:0][1:0]  op;
    logic [1:0][2:0]  line;
    logic [1:0][10:0] rda;
    logic [1:0][7:0]  rdd;

    osd_spi_ctrl #(.CLK_DIV(2), .LINE_BYTES(256)) u_a (
        .clk_sys(clk), .reset_n(rst_n[0]), .cmd_valid(vld[0]),
        .cmd_ready(rdy[0]), .cmd_op(op[0]), .cmd_line(line[0]),
        .rd_en(rde[0]), .rd_addr(rda[0]), .rd_data(rdd[0]),
        .busy(busy[0]), .done(done[0]), .SPI_SCK(sck[0]),
        .SPI_SS3(ss3[0]), .SPI_DI(di[0])
    );

    osd_spi_ctrl #(.CLK_DIV(1), .LINE_BYTES(4)) u_b (
        .clk_sys(clk), .reset_n(rst_n[1]), .cmd_valid(vld[1]),
        .cmd_ready(rdy[1]), .cmd_op(op[1]), .cmd_line(line[1]),
        .rd_en(rde[1]), .rd_addr(rda[1]), .rd_data(rdd[1]),
        .busy(busy[1]), .done(done[1]), .SPI_SCK(sck[1]),
        .SPI_SS3(ss3[1]), .SPI_DI(di[1])
    );

    typedef struct packed {
        logic        ss3;
        logic        sck;
        logic        di;
        logic        di_chk;
        logic        rd_en;
        logic        done;
        logic        rdy;
        logic [10:0] addr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int   acc_cnt[2], done_cnt[2], acc_cyc[2], done_cyc[2];
    int   edges[2], rx_bytes[2], rx_bits[2], ss_low[2];
    logic [7:0] rx_sr[2], rx_cmd[2];
    logic osd_en[2], prev_sck[2], prev_ss[2];
    logic [7:0] rx_buf[2][2048];
    int   rd_cnt[2048];

    function automatic int divk(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int lbk(input int k);
        return (k == 0) ? 256 : 4;
    endfunction

    function automatic logic [7:0] ram_byte(input logic [10:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? qa.size() : qb.size();
    endfunction

    task automatic qpush(input int k, input int n, input exp_t e);
        for (int i = 0; i < n; i++) begin
            if (k == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    function automatic exp_t qpop(input int k);
        if (k == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    task automatic qclear(input int k);
        if (k == 0) qa.delete();
        else        qb.delete();
    endtask

    task automatic chk(input int k, input string nm,
                       input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL u%0d.%s @cyc %0d: got %0h required %0h",
                     k, nm, cyc, act, expv);
        end
    endtask

    // expected per-cycle waveform after an accept, from the protocol timing
    task automatic build(input int k, input logic [1:0] o,
                         input logic [2:0] l);
        exp_t e;
        logic [7:0] cmd, by;
        int d, nb;
        d = divk(k);
        e = '0;
        e.ss3 = 1'b1;
        if (o == 2'd3) begin
            e.done = 1'b1;
            qpush(k, 1, e);
            return;
        end
        cmd = (o == 2'd0) ? 8'h40 : (o == 2'd1) ? 8'h41 : (8'h20 + 8'(l));
        nb  = (o == 2'd2) ? lbk(k) + 1 : 1;
        e = '0;
        e.di_chk = 1'b1;
        e.di = cmd[7];
        qpush(k, d, e);
        for (int b = 0; b < nb; b++) begin
            by = (b == 0) ? cmd : ram_byte({l, 8'(b - 1)});
            if (b > 0) begin
                e = '0;
                e.rd_en = 1'b1;
                e.addr = {l, 8'(b - 1)};
                qpush(k, 1, e);
                e.rd_en = 1'b0;
                qpush(k, 1, e);
            end
            for (int i = 7; i >= 0; i--) begin
                e = '0;
                e.di_chk = 1'b1;
                e.di = by[i];
                qpush(k, d, e);
                e.sck = 1'b1;
                qpush(k, d, e);
            end
        end
        e = '0;
        e.ss3 = 1'b1;
        qpush(k, 2 * d, e);
        e.done = 1'b1;
        qpush(k, 1, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic idle;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            idle = (qsize(k) == 0);
            e = '0;
            if (!rst_n[k]) begin
                qclear(k);
                idle = 1'b0;
                e.ss3 = 1'b1;
                e.rdy = 1'b1;
                e.di_chk = 1'b1;
            end else if (idle) begin
                e.ss3 = 1'b1;
                e.rdy = 1'b1;
            end else begin
                e = qpop(k);
            end
            chk(k, "ss3",   32'(ss3[k]),  32'(e.ss3));
            chk(k, "sck",   32'(sck[k]),  32'(e.sck));
            chk(k, "ready", 32'(rdy[k]),  32'(e.rdy));
            chk(k, "busy",  32'(busy[k]), 32'(!e.rdy));
            chk(k, "done",  32'(done[k]), 32'(e.done));
            chk(k, "rd_en", 32'(rde[k]),  32'(e.rd_en));
            if (e.di_chk)
                chk(k, "di", 32'(di[k]), 32'(e.di));
            if (e.rd_en || !rst_n[k])
                chk(k, "rd_addr", 32'(rda[k]), 32'(e.addr));

            if (done[k] === 1'b1) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
            if (ss3[k] === 1'b0)
                ss_low[k]++;

            if (prev_ss[k] && !ss3[k]) begin
                rx_bits[k]  = 0;
                rx_bytes[k] = 0;
            end
            if (ss3[k] !== 1'b0) begin
                rx_bits[k] = 0;
            end else if (!prev_sck[k] && sck[k]) begin
                edges[k]++;
                rx_sr[k] = {rx_sr[k][6:0], di[k]};
                rx_bits[k]++;
                if (rx_bits[k] == 8) begin
                    rx_bits[k] = 0;
                    if (rx_bytes[k] == 0) begin
                        rx_cmd[k] = rx_sr[k];
                        if (rx_sr[k] == 8'h40) osd_en[k] = 1'b0;
                        if (rx_sr[k] == 8'h41) osd_en[k] = 1'b1;
                    end else if (rx_cmd[k][7:3] == 5'b00100 &&
                                 rx_bytes[k] <= 256) begin
                        rx_buf[k][{rx_cmd[k][2:0], 8'(rx_bytes[k] - 1)}] = rx_sr[k];
                    end
                    rx_bytes[k]++;
                end
            end
            prev_sck[k] = sck[k];
            prev_ss[k]  = ss3[k];

            if (rst_n[k] && idle && vld[k]) begin
                acc_cnt[k]++;
                acc_cyc[k] = cyc;
                build(k, op[k], line[k]);
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rde[k] === 1'b1) begin
                rdd[k] <= ram_byte(rda[k]);
                if (k == 0) rd_cnt[rda[k]]++;
            end
        end
    end

    function automatic int cur(input int k, input int sel);
        return (sel == 0) ? acc_cnt[k] : done_cnt[k];
    endfunction

    task automatic wait_for(input string nm, input int k, input int sel,
                            input int target, input int budget);
        int t;
        t = 0;
        while (cur(k, sel) < target && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (cur(k, sel) < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL u%0d.%s: timeout, count %0d required %0d",
                     k, nm, cur(k, sel), target);
        end
    endtask

    task automatic start_cmd(input int k, input logic [1:0] o,
                             input logic [2:0] l);
        int a;
        @(posedge clk);
        #1;
        op[k] = o;
        line[k] = l;
        vld[k] = 1'b1;
        a = acc_cnt[k];
        wait_for("accept", k, 0, a + 1, 10);
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
        op[k] = 2'd0;
        line[k] = 3'd7;
    endtask

    task automatic run_cmd(input int k, input logic [1:0] o,
                           input logic [2:0] l, input int budget);
        int d;
        d = done_cnt[k];
        start_cmd(k, o, l);
        wait_for("done", k, 1, d + 1, budget);
    endtask

    int m_edges, m_low, m_done, fd, bad;

    initial begin
        rst_n = 2'b00;
        vld = 2'b00;
        op = '0;
        line = '0;
        rdd = '0;
        for (int k = 0; k < 2; k++) begin
            acc_cnt[k] = 0; done_cnt[k] = 0; acc_cyc[k] = 0;
            done_cyc[k] = 0; edges[k] = 0; rx_bytes[k] = 0;
            rx_bits[k] = 0; ss_low[k] = 0; rx_sr[k] = 8'h00;
            rx_cmd[k] = 8'h00; osd_en[k] = 1'b0;
            prev_sck[k] = 1'b0; prev_ss[k] = 1'b1;
        end
        for (int i = 0; i < 2048; i++) rd_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk(0, "rst_ss3",   32'(ss3[0]), 32'd1);
        chk(0, "rst_sck",   32'(sck[0]), 32'd0);
        chk(0, "rst_ready", 32'(rdy[0]), 32'd1);
        chk(0, "rst_addr",  32'(rda[0]), 32'd0);
        rst_n = 2'b11;

        // enable on CLK_DIV=2
        m_edges = edges[0];
        run_cmd(0, 2'd1, 3'd0, 200);
        chk(0, "en_len",   32'(done_cyc[0] - acc_cyc[0] + 1), 32'd40);
        chk(0, "en_cmd",   32'(rx_cmd[0]), 32'h41);
        chk(0, "en_osd",   32'(osd_en[0]), 32'd1);
        chk(0, "en_edges", 32'(edges[0] - m_edges), 32'd8);

        // disable then enable with cmd_valid held
        @(posedge clk);
        #1;
        op[0] = 2'd0;
        vld[0] = 1'b1;
        m_done = done_cnt[0];
        fd = acc_cnt[0];
        wait_for("b2b_acc1", 0, 0, fd + 1, 10);
        @(posedge clk);
        #1;
        op[0] = 2'd1;
        wait_for("b2b_done1", 0, 1, m_done + 1, 200);
        chk(0, "b2b_osd0", 32'(osd_en[0]), 32'd0);
        wait_for("b2b_acc2", 0, 0, fd + 2, 10);
        chk(0, "b2b_gap", 32'(acc_cyc[0]), 32'(done_cyc[0] + 1));
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        wait_for("b2b_done2", 0, 1, m_done + 2, 200);
        chk(0, "b2b_osd1", 32'(osd_en[0]), 32'd1);

        // full line write, line 5
        for (int i = 0; i < 2048; i++) rd_cnt[i] = 0;
        m_edges = edges[0];
        run_cmd(0, 2'd2, 3'd5, 20000);
        chk(0, "wr_len",   32'(done_cyc[0] - acc_cyc[0] + 1), 32'd8744);
        chk(0, "wr_edges", 32'(edges[0] - m_edges), 32'd2056);
        chk(0, "wr_cmd",   32'(rx_cmd[0]), 32'h25);
        chk(0, "wr_bytes", 32'(rx_bytes[0]), 32'd257);
        chk(0, "wr_first", 32'(rx_buf[0][11'h500]), 32'hA5);
        chk(0, "wr_last",  32'(rx_buf[0][11'h5FF]), 32'h5A);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            logic [10:0] a;
            a = {3'd5, 8'(i)};
            if (rx_buf[0][a] !== (8'(i) ^ 8'hA5)) bad++;
        end
        chk(0, "wr_buf_bad", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i >= 'h500 && i <= 'h5FF) begin
                if (rd_cnt[i] != 1) bad++;
            end else if (rd_cnt[i] != 0) begin
                bad++;
            end
        end
        chk(0, "wr_reads_bad", 32'(bad), 32'd0);

        // CLK_DIV=1, LINE_BYTES=4, line 0
        m_edges = edges[1];
        m_done = done_cnt[1];
        run_cmd(1, 2'd2, 3'd0, 500);
        repeat (10) @(posedge clk);
        #1;
        chk(1, "w4_len",   32'(done_cyc[1] - acc_cyc[1] + 1), 32'd93);
        chk(1, "w4_edges", 32'(edges[1] - m_edges), 32'd40);
        chk(1, "w4_dones", 32'(done_cnt[1] - m_done), 32'd1);
        chk(1, "w4_cmd",   32'(rx_cmd[1]), 32'h20);
        chk(1, "w4_b0",    32'(rx_buf[1][0]), 32'hA5);
        chk(1, "w4_b1",    32'(rx_buf[1][1]), 32'hA4);
        chk(1, "w4_b2",    32'(rx_buf[1][2]), 32'hA7);
        chk(1, "w4_b3",    32'(rx_buf[1][3]), 32'hA6);

        // reserved opcode
        m_edges = edges[1];
        m_low = ss_low[1];
        run_cmd(1, 2'd3, 3'd1, 20);
        chk(1, "nop_len",   32'(done_cyc[1] - acc_cyc[1] + 1), 32'd2);
        chk(1, "nop_edges", 32'(edges[1] - m_edges), 32'd0);
        chk(1, "nop_ss3",   32'(ss_low[1] - m_low), 32'd0);

        // reset in the middle of payload byte 100
        start_cmd(0, 2'd2, 3'd2);
        fd = 0;
        while (!(rx_bytes[0] == 100 && rx_bits[0] >= 4) && fd < 10000) begin
            @(negedge clk);
            #1;
            fd++;
        end
        chk(0, "rst_reach", 32'(rx_bytes[0]), 32'd100);
        m_done = done_cnt[0];
        @(posedge clk);
        #3;
        rst_n[0] = 1'b0;
        #1;
        chk(0, "mid_ss3", 32'(ss3[0]), 32'd1);
        chk(0, "mid_sck", 32'(sck[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "mid_nodone", 32'(done_cnt[0] - m_done), 32'd0);
        run_cmd(0, 2'd1, 3'd0, 200);
        chk(0, "post_len",   32'(done_cyc[0] - acc_cyc[0] + 1), 32'd40);
        chk(0, "post_cmd",   32'(rx_cmd[0]), 32'h41);
        chk(0, "post_bytes", 32'(rx_bytes[0]), 32'd1);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
